// File: rtl/epg_design.sv
// Registered even/odd parity generator.
// Accepts one data word per clock when in_valid is high and presents, one
// cycle later, the parity bit, the {P, A} codeword and the popcount of A.
//
// Handshake: valid-only streaming, with no ready/backpressure.
// - A word is taken on every rising edge where in_valid=1.
// - The edge that takes a word raises out_valid for exactly one cycle,
//   together with the matching P, code_out and ones_count.
// - An edge with in_valid=0 drops out_valid and leaves the data outputs
//   holding the last accepted word.
// - A and odd_sel are ignored whenever in_valid=0.
module epg_design #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic             in_valid,
  input  logic             odd_sel,
  output logic             P,
  output logic             out_valid,
  output logic [WIDTH:0]   code_out,
  output logic [CNT_W-1:0] ones_count
);

  logic             p_q,         p_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   code_q,      code_d;
  logic [CNT_W-1:0] ones_q,      ones_d;

  logic             parity;
  logic [CNT_W-1:0] pop;

  // Parity and popcount of the incoming word. These feed only the
  // registers, so there is no combinational path from A to an output.
  always_comb begin
    parity = (^A) ^ odd_sel;
    pop    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + CNT_W'(A[i]);
    end
  end

  // Next-state: load a new result on an accepted word, otherwise hold.
  always_comb begin
    p_d         = p_q;
    code_d      = code_q;
    ones_d      = ones_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      p_d    = parity;
      code_d = {parity, A};
      ones_d = pop;
    end
  end

  // Output registers. The asynchronous reset also discards a result that
  // has been accepted but not yet seen downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= 1'b0;
      out_valid_q <= 1'b0;
      code_q      <= '0;
      ones_q      <= '0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      ones_q      <= ones_d;
    end
  end

  assign P          = p_q;
  assign out_valid  = out_valid_q;
  assign code_out   = code_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_epg_design.sv
// Bench for epg_design: a driver pushes reference-model results into a
// queue, and a monitor on the falling edge pops and compares them.
module tb_epg_design;

  localparam int WIDTH = 8;
  localparam int CNT_W = 7;
  // Expected item layout: {odd_sel, code_out, ones_count}
  localparam int W = 1 + (WIDTH + 1) + CNT_W;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] A = '0;
  logic             in_valid = 1'b0;
  logic             odd_sel = 1'b0;
  logic             P;
  logic             out_valid;
  logic [WIDTH:0]   code_out;
  logic [CNT_W-1:0] ones_count;

  always #5 clk = ~clk;

  epg_design #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .in_valid   (in_valid),
    .odd_sel    (odd_sel),
    .P          (P),
    .out_valid  (out_valid),
    .code_out   (code_out),
    .ones_count (ones_count)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count the ones, then choose the parity bit that makes
  // the total count even (odd_sel=0) or odd (odd_sel=1).
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a, input logic odd);
    int ones;
    logic p;
    ones = $countones(a);
    p = ((ones % 2) == 1) ? ~odd : odd;
    return {odd, p, a, CNT_W'(ones)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [WIDTH-1:0] a, input logic odd, input logic v);
    @(posedge clk);
    #1;
    A = a;
    odd_sel = odd;
    in_valid = v;
    if (v) exp_q.push_back(model(a, odd));
  endtask

  task automatic idle_random();
    drive(WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_code", 64'(code_out), 64'd0);
      check("reset_ones", 64'(ones_count), 64'd0);
      last_exp = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("code_out", 64'(code_out), 64'(e[W-2 -: WIDTH+1]));
        check("P", 64'(P), 64'(e[W-2]));
        check("ones_count", 64'(ones_count), 64'(e[CNT_W-1:0]));
        check("codeword_parity", 64'($countones(code_out) % 2), 64'(e[W-1]));
        last_exp = e;
      end
    end else begin
      check("hold_code", 64'(code_out), 64'(last_exp[W-2 -: WIDTH+1]));
      check("hold_P", 64'(P), 64'(last_exp[W-2]));
      check("hold_ones", 64'(ones_count), 64'(last_exp[CNT_W-1:0]));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] stream [12] = '{
    8'b10101010, 8'b11101010, 8'b10111010, 8'b10101110,
    8'b10101011, 8'b10101000, 8'b10100010, 8'b10101010,
    8'b10100010, 8'b11111110, 8'b00101010, 8'b10001010
  };

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back even-parity stream.
    foreach (stream[i]) drive(stream[i], 1'b0, 1'b1);
    // Extremes.
    drive(8'h00, 1'b0, 1'b1);
    drive(8'hFF, 1'b0, 1'b1);
    drive(8'h00, 1'b1, 1'b1);
    drive(8'hFF, 1'b1, 1'b1);
    // Odd mode.
    drive(8'b10101010, 1'b1, 1'b1);
    // Hold across gaps while A and odd_sel toggle.
    drive(8'b11111110, 1'b0, 1'b1);
    repeat (3) idle_random();
    idle_random();

    // Asynchronous reset mid-cycle, discarding a just-accepted word.
    drive(8'b11111110, 1'b0, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_P", 64'(P), 64'd0);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_code", 64'(code_out), 64'd0);
    check("async_ones", 64'(ones_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) idle_random();

    // Randomized traffic.
    for (int n = 0; n < 1000; n++) begin
      drive(WIDTH'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    repeat (3) idle_random();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/epg_design.md
Name: epg_design

Overview:
- Registered even-parity generator for a parallel data word (default 8 bits).
- Computes P so that the total count of 1s across the data word plus P is even.
- Also emits the parity-protected codeword and the popcount of the word.
- Sits on a datapath ahead of storage/transmit logic that needs a parity bit per word.

Parameters:
- WIDTH, 8, data word width in bits (legal range 1..64).
- CNT_W, 7, width of ones_count; must satisfy 2^CNT_W > WIDTH (7 covers WIDTH up to 64).

Ports:
- clk  input  1  rising-edge clock; all state updates on the posedge.
- rst  input  1  reset, asynchronous and active-high; clears all registers immediately.
- A  input  WIDTH  data word to protect.
- in_valid  input  1  A is sampled only when high.
- odd_sel  input  1  0 = even parity (default use), 1 = odd parity (P inverted).
- P  output  1  registered parity bit for the last accepted word.
- out_valid  output  1  high for exactly one cycle per accepted word, aligned with P.
- code_out  output  WIDTH+1  registered codeword {P, A}: P is the MSB, A occupies [WIDTH-1:0].
- ones_count  output  CNT_W  registered number of 1s in the last accepted A.

Behaviour:
- Parity: P = XOR-reduction of all WIDTH bits of A, XOR odd_sel.
  - With odd_sel=0, popcount(A)+P is even.
  - With odd_sel=1, popcount(A)+P is odd.
- Latency: one cycle.
  - A word accepted on posedge N (in_valid=1) drives P, code_out, ones_count and out_valid=1 after posedge N.
  - These values are visible during the cycle between posedge N and posedge N+1.
- Throughput: one word per clock; back-to-back in_valid accepts every word with no bubbles.
- in_valid=0 at a posedge:
  - out_valid goes to 0.
  - P, code_out and ones_count hold their previous values.
- odd_sel is sampled together with A on the same accepting edge. Changing it while in_valid=0 has no effect on the outputs.
- ones_count: unsigned popcount of A, zero-extended to CNT_W. Range 0..WIDTH.
- Reset (rst=1, asynchronous):
  - P=0, out_valid=0, code_out=0, ones_count=0 immediately, independent of clk.
  - The registers stay cleared while rst is held.
  - The first posedge after rst deasserts behaves as normal operation.
- Reset mid-stream: an accepted word whose outputs have not yet been consumed is discarded. No out_valid pulse is produced for it after reset releases.
- Boundaries:
  - A all zeros → P=odd_sel, ones_count=0.
  - A all ones → P=(WIDTH mod 2) XOR odd_sel, ones_count=WIDTH.
- No X propagation: when in_valid=0, the value on A must not affect any output.
- Purely synchronous datapath apart from the async reset. No combinational path from A to any output.

Test Plan:
- Reset: assert rst mid-cycle with outputs nonzero → P, out_valid, code_out and ones_count go to 0 immediately, without waiting for a clock edge.
- Even parity stream, odd_sel=0, in_valid=1, back-to-back, one cycle latency:
  - A=8'b10101010 → P=0, ones_count=4, code_out=9'b010101010.
  - A=8'b11101010 → P=1, ones_count=5.
  - A=8'b10111010 → P=1.
  - A=8'b10101110 → P=1.
  - A=8'b10101011 → P=1.
  - A=8'b10101000 → P=1, ones_count=3.
  - A=8'b10100010 → P=1.
  - A=8'b10101010 → P=0.
  - A=8'b10100010 → P=1.
  - A=8'b11111110 → P=1, ones_count=7.
  - A=8'b00101010 → P=1.
  - A=8'b10001010 → P=1.
  - out_valid stays high throughout the stream.
- Extremes, odd_sel=0:
  - A=8'h00 → P=0, ones_count=0.
  - A=8'hFF → P=0, ones_count=8, code_out=9'h0FF.
- Odd mode: odd_sel=1, A=8'b10101010 → P=1, code_out=9'b110101010. Self-check that popcount(code_out) is odd.
- Hold/gaps: accept 8'b11111110, then drop in_valid for 3 cycles while toggling A and odd_sel → out_valid=0 on each of those cycles, P stays 1 and ones_count stays 7.
- Randomized: 1000 words with random in_valid, odd_sel and A → the parity of code_out matches odd_sel on every out_valid cycle.
